// File: rtl/pwm_led_multi_pkg.sv
// Shared definitions for the multi-channel breathing-LED PWM driver:
// per-channel mode encoding and a counter-width helper.
package pwm_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'b00,
      MODE_SOLID  = 2'b01,
      MODE_BREATH = 2'b10,
      MODE_BLINK  = 2'b11
   } led_mode_e;

   // Bits needed for a counter holding 0..n-1 (never narrower than one bit).
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pwm_led_multi_if.sv
// Control/status bundle of the PWM LED driver: run enable, per-channel modes,
// LED pins and the end-of-period strobe.
interface pwm_led_multi_if #(
   parameter int CH_NUM = 4
);
   logic                  en;
   logic [2*CH_NUM-1:0]   mode;
   logic [CH_NUM-1:0]     led;
   logic                  period_end;

   modport master (output en, output mode, input led, input period_end);
   modport slave  (input en, input mode, output led, output period_end);
endinterface

// File: rtl/pwm_led_multi_ch.sv
// One LED channel: latched mode, triangular duty ramp and the registered
// PWM output bit driven from the shared timebase.
module pwm_led_ch
   import pwm_pkg::*;
#(
   parameter  int RES       = 1000,
   parameter  int INIT_DUTY = 0,
   localparam int POS_W     = cnt_w(RES),
   localparam int DW        = cnt_w(RES + 1)
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             en,
   input  logic             pe,
   input  logic             step,
   input  logic [POS_W-1:0] cnt_pos,
   input  logic             blink_ph,
   input  led_mode_e        mode,
   output logic             led
);

   localparam logic [DW-1:0] D_MAX  = DW'(RES);
   localparam logic [DW-1:0] D_INIT = DW'(INIT_DUTY);
   localparam logic [DW-1:0] D_ONE  = DW'(1);
   localparam logic [DW-1:0] D_ZERO = '0;

   led_mode_e       mode_q;
   logic [DW-1:0]   d;
   logic            dir;
   logic            led_nxt;

   // Mode only changes on a period boundary so a running period is never cut short.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         mode_q <= MODE_OFF;
      end else if (pe || !en) begin
         mode_q <= mode;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         d   <= D_INIT;
         dir <= 1'b0;
      end else if (step) begin
         if (!dir) begin
            if (d == D_MAX) begin
               d   <= D_MAX - D_ONE;
               dir <= 1'b1;
            end else begin
               d <= d + D_ONE;
            end
         end else begin
            if (d == D_ZERO) begin
               d   <= D_ONE;
               dir <= 1'b0;
            end else begin
               d <= d - D_ONE;
            end
         end
      end
   end

   // cnt_pos never reaches RES, so d==RES is solid high and d==0 solid low.
   always_comb begin
      led_nxt = 1'b0;
      case (mode_q)
         MODE_OFF:    led_nxt = 1'b0;
         MODE_SOLID:  led_nxt = 1'b1;
         MODE_BREATH: led_nxt = (DW'(cnt_pos) < d);
         MODE_BLINK:  led_nxt = blink_ph;
         default:     led_nxt = 1'b0;
      endcase
      if (!en) begin
         led_nxt = 1'b0;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         led <= 1'b0;
      end else begin
         led <= led_nxt;
      end
   end

endmodule

// File: rtl/pwm_led_multi.sv
// Multi-channel breathing-LED PWM driver: one shared prescaler / position /
// hold / blink timebase feeding CH_NUM phase-staggered channels.
module pwm_led_multi
   import pwm_pkg::*;
#(
   parameter int CH_NUM = 4,
   parameter int PRESC  = 100,
   parameter int RES    = 1000,
   parameter int HOLD   = 1,
   parameter int BLINK  = 250
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   pwm_led_multi_if.slave     bus
);

   localparam int PW    = cnt_w(PRESC);
   localparam int POS_W = cnt_w(RES);
   localparam int HW    = cnt_w(HOLD);
   localparam int BW    = cnt_w(BLINK);

   localparam logic [PW-1:0]    PRE_LAST   = PW'(PRESC - 1);
   localparam logic [POS_W-1:0] POS_LAST   = POS_W'(RES - 1);
   localparam logic [HW-1:0]    HOLD_LAST  = HW'(HOLD - 1);
   localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK - 1);
   localparam logic [PW-1:0]    PRE_ONE    = PW'(1);
   localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);
   localparam logic [HW-1:0]    HOLD_ONE   = HW'(1);
   localparam logic [BW-1:0]    BLINK_ONE  = BW'(1);

   logic [PW-1:0]     cnt_pre;
   logic [POS_W-1:0]  cnt_pos;
   logic [HW-1:0]     cnt_hold;
   logic [BW-1:0]     cnt_blink;
   logic              blink_ph;
   logic              period_end;
   logic              tick;
   logic              pe;
   logic              step;
   logic              blink_wrap;
   logic [CH_NUM-1:0] led_w;

   // Gating tick with en suppresses every downstream event while stopped.
   assign tick       = bus.en && (cnt_pre == PRE_LAST);
   assign pe         = tick && (cnt_pos == POS_LAST);
   assign step       = pe && (cnt_hold == HOLD_LAST);
   assign blink_wrap = pe && (cnt_blink == BLINK_LAST);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_pre <= '0;
         cnt_pos <= '0;
      end else if (!bus.en) begin
         cnt_pre <= '0;
         cnt_pos <= '0;
      end else if (tick) begin
         cnt_pre <= '0;
         cnt_pos <= (cnt_pos == POS_LAST) ? '0 : cnt_pos + POS_ONE;
      end else begin
         cnt_pre <= cnt_pre + PRE_ONE;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_hold  <= '0;
         cnt_blink <= '0;
      end else if (!bus.en) begin
         cnt_hold  <= '0;
         cnt_blink <= '0;
      end else if (pe) begin
         cnt_hold  <= (cnt_hold == HOLD_LAST) ? '0 : cnt_hold + HOLD_ONE;
         cnt_blink <= (cnt_blink == BLINK_LAST) ? '0 : cnt_blink + BLINK_ONE;
      end
   end

   // blink_ph survives en=0 so a paused blink resumes in the same half-cycle.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         blink_ph   <= 1'b0;
         period_end <= 1'b0;
      end else begin
         period_end <= pe;
         if (blink_wrap) begin
            blink_ph <= ~blink_ph;
         end
      end
   end

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      pwm_led_ch #(
         .RES       (RES),
         .INIT_DUTY ((i * RES) / CH_NUM)
      ) u_ch (
         .sys_clk   (sys_clk),
         .sys_rst_n (sys_rst_n),
         .en        (bus.en),
         .pe        (pe),
         .step      (step),
         .cnt_pos   (cnt_pos),
         .blink_ph  (blink_ph),
         .mode      (led_mode_e'(bus.mode[2*i +: 2])),
         .led       (led_w[i])
      );
   end

   assign bus.led        = led_w;
   assign bus.period_end = period_end;

endmodule

// File: tb/tb_pwm_led_multi.sv
// Directed bench for pwm_led_multi with CH_NUM=2 PRESC=2 RES=4 HOLD=1 BLINK=3
// (8 clocks per PWM period); each period's LED/strobe pattern is compared to hand values.
module tb_pwm_led_multi;

   localparam int CH_NUM = 2;
   localparam int PRESC  = 2;
   localparam int RES    = 4;
   localparam int HOLD   = 1;
   localparam int BLINK  = 3;

   logic sys_clk = 1'b0;
   logic sys_rst_n;
   int   checks = 0;
   int   errors = 0;

   pwm_led_multi_if #(.CH_NUM(CH_NUM)) bus ();

   pwm_led_multi #(
      .CH_NUM (CH_NUM),
      .PRESC  (PRESC),
      .RES    (RES),
      .HOLD   (HOLD),
      .BLINK  (BLINK)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   always #5 sys_clk = ~sys_clk;

   // Breathe pattern for duty d: high on the first 2*d clocks of the 8-clock period.
   function automatic logic [7:0] dmask(input int d);
      return 8'((1 << (2 * d)) - 1);
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One PWM period; bit j of each pattern is the value after the (j+1)-th clock.
   task automatic run_period(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input int chg_at, input logic [3:0] chg_mode);
      logic [7:0] p0, p1, pp;
      p0 = '0; p1 = '0; pp = '0;
      for (int j = 0; j < 8; j++) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
         p0[j] = bus.led[0];
         p1[j] = bus.led[1];
         pp[j] = bus.period_end;
         if (j + 1 == chg_at) bus.mode = chg_mode;
      end
      check({tag, " ch0"}, p0, e0);
      check({tag, " ch1"}, p1, e1);
      check({tag, " pe"},  pp, 8'h80);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         d0_tab [9];
      int         d1_tab [9];
      logic [7:0] blink_tab [8];
      logic [7:0] p0, p1, acc_led, acc_pe;

      d0_tab    = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
      d1_tab    = '{3, 4, 3, 2, 1, 0, 1, 2, 3};
      blink_tab = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};

      sys_rst_n = 1'b0;
      bus.en    = 1'b1;
      bus.mode  = 4'b1010;
      repeat (3) @(negedge sys_clk);
      check("reset led", {6'b0, bus.led}, 8'h00);
      check("reset pe",  {7'b0, bus.period_end}, 8'h00);
      sys_rst_n = 1'b1;

      // Period 0 runs with mode_q still OFF; first strobe on clock 8.
      run_period("p0", 8'h00, 8'h00, 0, 4'b0000);
      for (int k = 0; k < 9; k++)
         run_period($sformatf("breathe p%0d", k + 1), dmask(d0_tab[k]), dmask(d1_tab[k]), 0, 4'b0000);

      // ch0 breathe -> solid requested on clock 3; takes effect next period.
      run_period("p10 switch", 8'h0F, 8'hFF, 2, 4'b1001);
      run_period("p11 solid",  8'hFF, 8'h3F, 8, 4'b1111);
      run_period("p12",        8'hFF, 8'h0F, 0, 4'b0000);
      for (int k = 0; k < 8; k++)
         run_period($sformatf("blink p%0d", k + 13), blink_tab[k], blink_tab[k],
                    (k == 7) ? 8 : 0, 4'b1010);
      run_period("p21 blink", 8'hFF, 8'hFF, 0, 4'b0000);

      // Period 22: breathe d0=2 d1=0; en dropped after clock 4.
      p0 = '0; p1 = '0; acc_pe = '0;
      for (int j = 0; j < 4; j++) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
         p0[j] = bus.led[0];
         p1[j] = bus.led[1];
         acc_pe[j] = bus.period_end;
      end
      check("p22 ch0 pre-stop", p0, 8'h0F);
      check("p22 ch1 pre-stop", p1, 8'h00);
      check("p22 pe pre-stop",  acc_pe, 8'h00);
      bus.en = 1'b0;
      acc_led = '0; acc_pe = '0;
      for (int j = 0; j < 5; j++) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
         acc_led[j] = |bus.led;
         acc_pe[j]  = bus.period_end;
      end
      check("stopped led", acc_led, 8'h00);
      check("stopped pe",  acc_pe,  8'h00);
      bus.en = 1'b1;
      run_period("resume",   8'h0F, 8'h00, 0, 4'b0000);
      run_period("resume+1", 8'h03, 8'h03, 0, 4'b0000);

      // Mid-period asynchronous reset while ch1 is driving high.
      for (int j = 0; j < 2; j++) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
      end
      check("pre-reset led", {6'b0, bus.led}, 8'h02);
      #2 sys_rst_n = 1'b0;
      #1 check("async reset led", {6'b0, bus.led}, 8'h00);
      repeat (3) @(negedge sys_clk);
      check("held reset led", {6'b0, bus.led}, 8'h00);
      check("held reset pe",  {7'b0, bus.period_end}, 8'h00);
      sys_rst_n = 1'b1;
      run_period("post-rst p0", 8'h00, 8'h00, 0, 4'b0000);
      run_period("post-rst p1", 8'h03, 8'h3F, 0, 4'b0000);
      run_period("post-rst p2", 8'h0F, 8'hFF, 0, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
